// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions between the ALU issue stage and the ALU itself.
//   - ALU_OP_W and the ALU_OP_* operation encodings (shared with the ALU)
//   - RV32I major opcode constants used by the issue decoder
//   - issue_payload_t : the decoded payload carried from issue to execute
//   - small immediate-extraction helpers
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  // ALU operation encodings. The ALU decodes exactly these values, so any
  // change here must be made on both sides at once.
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ANDN = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LHS  = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RHS  = 4'd12;

  // RV32I major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 values that select the base and alternate operation groups.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded payload handed to the ALU / execute stage.
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [31:0]         lhs;
    logic [31:0]         rhs;
    logic [4:0]          rd;
    logic                wen;
    logic                illegal;
  } issue_payload_t;

  // Sign-extended I-type immediate.
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  // U-type immediate, already shifted into the upper 20 bits.
  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  // Zero-extended 5-bit shift amount of the immediate shifts.
  function automatic logic [31:0] imm_shamt(input logic [31:0] inst);
    return {27'b0, inst[24:20]};
  endfunction

endpackage

// File: rtl/alu_issue_decoder.sv
// ---------------------------------------------------------------------------
// alu_issue_decoder
// Purely combinational RV32I integer decode: turns an instruction word plus
// its PC and register read data into an ALU op, operands and writeback
// control.
//
// Ports:
//   inst    in   32  instruction word
//   pc      in   32  instruction PC
//   rs1     in   32  rs1 read data
//   rs2     in   32  rs2 read data
//   payload out      decoded issue_payload_t
//
// Configuration macro: ALU_ISSUE_ANDN_EN
//   defined   : OP funct7=0100000 funct3=111 decodes to ANDN
//   undefined : that encoding is illegal and ALU_OP_ANDN is never produced
// ---------------------------------------------------------------------------
module alu_issue_decoder
  import alu_pkg::*;
(
  input  logic [31:0]    inst,
  input  logic [31:0]    pc,
  input  logic [31:0]    rs1,
  input  logic [31:0]    rs2,
  output issue_payload_t payload
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [4:0]          rd;

  logic [ALU_OP_W-1:0] op;
  logic [31:0]         lhs;
  logic [31:0]         rhs;
  logic                illegal;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    op      = ALU_OP_ADD;
    lhs     = '0;
    rhs     = '0;
    illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        lhs = rs1;
        rhs = rs2;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: op = ALU_OP_ADD;
            3'b001: op = ALU_OP_SLL;
            3'b010: op = ALU_OP_SLT;
            3'b011: op = ALU_OP_SLTU;
            3'b100: op = ALU_OP_XOR;
            3'b101: op = ALU_OP_SRL;
            3'b110: op = ALU_OP_OR;
            3'b111: op = ALU_OP_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000: op = ALU_OP_SUB;
            3'b101: op = ALU_OP_SRA;
`ifdef ALU_ISSUE_ANDN_EN
            3'b111: op = ALU_OP_ANDN;
`endif
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        lhs = rs1;
        rhs = imm_i(inst);
        case (funct3)
          3'b000: op = ALU_OP_ADD;
          3'b010: op = ALU_OP_SLT;
          3'b011: op = ALU_OP_SLTU;
          3'b100: op = ALU_OP_XOR;
          3'b110: op = ALU_OP_OR;
          3'b111: op = ALU_OP_AND;
          // Immediate shifts reuse the upper immediate bits as funct7, so
          // the operand is only the 5-bit shamt and funct7 must be exact.
          3'b001: begin
            rhs = imm_shamt(inst);
            if (funct7 == F7_BASE) op = ALU_OP_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            rhs = imm_shamt(inst);
            if (funct7 == F7_BASE)     op = ALU_OP_SRL;
            else if (funct7 == F7_ALT) op = ALU_OP_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      OPC_LUI: begin
        op  = ALU_OP_RHS;
        lhs = '0;
        rhs = imm_u(inst);
      end

      OPC_AUIPC: begin
        op  = ALU_OP_ADD;
        lhs = pc;
        rhs = imm_u(inst);
      end

      default: illegal = 1'b1;
    endcase

    // An illegal instruction still flows down the pipe as a harmless ADD of
    // zeros so execute can raise the exception in program order.
    if (illegal) begin
      op  = ALU_OP_ADD;
      lhs = '0;
      rhs = '0;
    end
  end

  always_comb begin
    payload         = '0;
    payload.op      = op;
    payload.lhs     = lhs;
    payload.rhs     = rhs;
    payload.rd      = rd;
    payload.wen     = !illegal && (rd != 5'd0);
    payload.illegal = illegal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Decode / operand-select stage directly upstream of the ALU. Accepts one
// RV32I integer instruction per handshake, decodes it and presents the ALU
// payload from a registered output. A second (skid) register absorbs the one
// instruction that can arrive while the output is stalled, so in_ready is
// driven straight from a flop.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop all buffered and incoming work
//   in_valid     upstream holds a valid instruction
//   in_ready     stage can accept (= !skid_valid, registered)
//   in_inst      instruction word
//   in_pc        instruction PC
//   in_rs1/2     register read data, valid with in_valid
//   out_valid    payload valid
//   out_ready    execute consumes the payload
//   out_op       ALU operation (alu_pkg encoding)
//   out_lhs/rhs  ALU operands
//   out_rd       destination register
//   out_wen      write rd
//   out_illegal  unsupported encoding
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; out_valid never drops and the output payload never changes while
// out_ready is low.
//
// Configuration macro: ALU_ISSUE_ANDN_EN (see alu_issue_decoder).
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_op,
  output logic [XLEN-1:0]     out_lhs,
  output logic [XLEN-1:0]     out_rhs,
  output logic [4:0]          out_rd,
  output logic                out_wen,
  output logic                out_illegal
);

  issue_payload_t dec_payload;
  issue_payload_t main_q;
  issue_payload_t skid_q;
  logic           main_valid;
  logic           skid_valid;
  logic           accept;

  alu_issue_decoder u_decoder (
    .inst    (in_inst),
    .pc      (in_pc),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .payload (dec_payload)
  );

  // The stage can take a new instruction whenever the skid slot is free,
  // independent of out_ready in the current cycle.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  // Invariant: skid_valid implies main_valid. The skid slot is only filled
  // while main is occupied and stalled, and it is emptied into main before
  // main can ever go empty, which keeps the two in FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Flush overrides everything, including an accept in this cycle.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Nothing is accepted while skid is full; move it up when main drains.
      if (out_ready) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || out_ready) begin
      // Main is empty or draining this edge: new work goes straight to main.
      main_valid <= accept;
      if (accept) begin
        main_q <= dec_payload;
      end
    end else if (accept) begin
      // Main is full and stalled: park the incoming instruction in skid.
      skid_q     <= dec_payload;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_op      = main_q.op;
  assign out_lhs     = main_q.lhs;
  assign out_rhs     = main_q.rhs;
  assign out_rd      = main_q.rd;
  assign out_wen     = main_q.wen;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage. The reference model is an ordered
// queue of up to two decoded instructions; the decoder reference is written
// from the instruction-set tables with plain field arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int PW = $bits(issue_payload_t);

`ifdef ALU_ISSUE_ANDN_EN
  localparam bit ANDN_ON = 1'b1;
`else
  localparam bit ANDN_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_lhs, out_rhs;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_lhs     (out_lhs),
    .out_rhs     (out_rhs),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference decoder ----------------
  // Operation numbers written straight from the shared encoding table.
  function automatic issue_payload_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                                input logic [31:0] a, input logic [31:0] b);
    issue_payload_t p;
    int r_ops [8];
    int i_ops [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    int op;
    logic [31:0] l, r;
    // funct3 -> op for OP funct7=0 and for OP-IMM (-1 marks the shift slots)
    r_ops = '{0, 6, 9, 10, 2, 7, 5, 3};
    i_ops = '{0, -1, 9, 10, 2, -1, 5, 3};
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    ok = 1'b0; op = 0; l = 0; r = 0;
    if (opc == 7'h33) begin
      l = a; r = b;
      if (f7 == 7'h00) begin ok = 1'b1; op = r_ops[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; op = 1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 8; end
      else if (f7 == 7'h20 && f3 == 3'd7 && ANDN_ON) begin ok = 1'b1; op = 4; end
    end else if (opc == 7'h13) begin
      l = a;
      if (i_ops[f3] >= 0) begin
        ok = 1'b1; op = i_ops[f3];
        r = 32'(signed'(inst) >>> 20);
      end else begin
        r = 32'(inst[24:20]);
        if (f7 == 7'h00) begin ok = 1'b1; op = (f3 == 3'd1) ? 6 : 7; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 8; end
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1; op = 12; l = 0; r = inst & 32'hFFFF_F000;
    end else if (opc == 7'h17) begin
      ok = 1'b1; op = 0; l = pc; r = inst & 32'hFFFF_F000;
    end
    if (!ok) begin op = 0; l = 0; r = 0; end
    p.op      = 4'(op);
    p.lhs     = l;
    p.rhs     = r;
    p.rd      = inst[11:7];
    p.wen     = ok && (inst[11:7] != 5'd0);
    p.illegal = !ok;
    return p;
  endfunction

  // rd of an illegal instruction carries no meaning, so it is not compared.
  function automatic logic [PW-1:0] norm(input issue_payload_t p);
    if (p.illegal) p.rd = '0;
    return p;
  endfunction

  // ---------------- reference model: ordered 2-slot buffer ----------------
  logic [PW-1:0] exp_q[$];
  bit m_acc, m_drn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_acc = in_valid && (exp_q.size() < 2);
      m_drn = (exp_q.size() > 0) && out_ready;
      if (m_drn) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back(norm(ref_decode(in_inst, in_pc, in_rs1, in_rs2)));
    end
  end

  // ---------------- compare process (opposite edge) ----------------
  issue_payload_t dut_p;
  always @(negedge clk) begin
    dut_p.op = out_op; dut_p.lhs = out_lhs; dut_p.rhs = out_rhs;
    dut_p.rd = out_rd; dut_p.wen = out_wen; dut_p.illegal = out_illegal;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (out_valid && exp_q.size() > 0)
      check("payload", norm(dut_p), exp_q[0]);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = $urandom;
    in_rs1   = a;
    in_rs2   = b;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
      1: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h13;
      4: begin
        w[6:0] = 7'h13; w[12] = 1'b1;
        w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 : (($urandom_range(0, 1) == 0) ? 7'h20 : w[31:25]);
      end
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  int seen;

  // ---------------- main sequence ----------------
  initial begin
    issue_payload_t e;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    #3;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst payload", {out_op, out_lhs, out_rhs, out_rd, out_wen, out_illegal}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Pin the reference decoder to hand-computed values.
    e = ref_decode(32'h002081B3, 0, 5, 7);
    check("pin add", e, {4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0});
    e = ref_decode(32'h40335293, 0, 32'h80, 0);
    check("pin srai", e, {4'd8, 32'h80, 32'd3, 5'd5, 1'b1, 1'b0});
    e = ref_decode(32'hFFF00093, 0, 9, 0);
    check("pin addi", e, {4'd0, 32'd9, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0});
    e = ref_decode(32'h12345137, 0, 9, 9);
    check("pin lui", e, {4'd12, 32'd0, 32'h1234_5000, 5'd2, 1'b1, 1'b0});
    e = ref_decode(32'hFFFFFFFF, 0, 9, 9);
    check("pin all-ones", {e.op, e.lhs, e.rhs, e.wen, e.illegal}, {4'd0, 64'd0, 1'b0, 1'b1});

    // add x3,x1,x2 with a free output: one-cycle latency.
    out_ready = 1'b1;
    drive(32'h002081B3, 5, 7);
    step();
    check("add latency", {out_valid, out_op, out_lhs, out_rhs, out_rd, out_wen},
          {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1});
    drive(32'h40335293, 32'hF000_0000, 0); step();
    drive(32'hFFF00093, 0, 0);             step();
    drive(32'h12345137, 0, 0);             step();
    in_valid = 1'b0; step();

    // Backpressure: two accepted, third held off until skid drains.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h11, 1); step();
    drive(32'h002081B3, 32'h22, 2); step();
    check("bp in_ready low", in_ready, 0);
    drive(32'h002081B3, 32'h33, 3); step(); step();
    check("bp hold A", {out_valid, out_lhs}, {1'b1, 32'h11});
    out_ready = 1'b1; step();
    check("bp B next", {out_valid, out_lhs}, {1'b1, 32'h22});
    step();
    check("bp C last", {out_valid, out_lhs}, {1'b1, 32'h33});
    in_valid = 1'b0; step();

    // ANDN and an all-ones word.
    drive(32'h4020F1B3, 32'hFF, 32'h0F); step();
    check("andn", {out_op, out_illegal, out_wen},
          ANDN_ON ? {4'd4, 1'b0, 1'b1} : {4'd0, 1'b1, 1'b0});
    drive(32'hFFFFFFFF, 1, 2); step();
    check("ones illegal", {out_illegal, out_wen}, {1'b1, 1'b0});
    in_valid = 1'b0; step();

    // Flush with main and skid full and an incoming instruction.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'hA1, 0); step();
    drive(32'h002081B3, 32'hA2, 0); step();
    drive(32'h002081B3, 32'hA3, 0); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", out_valid, 0);
    check("flush in_ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin step(); if (out_valid) seen++; end
    check("flush nothing emerges", seen, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'hB1, 0); step();
    drive(32'h002081B3, 32'hB2, 0); step();
    drive(32'h002081B3, 32'hB3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(32'h002081B3, 32'hC7, 32'h1);
    step();
    check("post-rst first", {out_valid, out_lhs, out_rhs}, {1'b1, 32'hC7, 32'h1});
    in_valid = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
